tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_sched_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 42 ++++
 rtl/tick_scheduler.sv | 123 ++++++++++++
 tb/tb_tick_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared state encoding and prescale helper for tick_scheduler
//   state_t        : scheduler FSM states
//   calc_prescale  : clk cycles per base tick (integer division)
package tick_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int calc_prescale(input int ref_hz, input int base_hz);
      return ref_hz / base_hz;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - base tick generator counting 0..PRESCALE-1
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable (scheduler active)
//   clr   : synchronous clear of the count
//   tick  : high for the one cycle the count sits at PRESCALE-1 while enabled
module tick_prescaler #(
   parameter int PRESCALE = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = en && (count_q == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel clock-enable strobe scheduler
//   clk, reset          : system clock, asynchronous active-low reset
//   cfg_valid/cfg_ready : divide-ratio write handshake (cfg_ready high once out of reset)
//   cfg_ch, cfg_div     : target channel and divide ratio in base ticks (0 disables)
//   start, stop         : one-cycle run / halt commands (stop wins when both high)
//   tick_en             : registered per-channel one-cycle strobes
//   busy                : registered, high while the FSM is not IDLE
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int REF_FREQUENCY  = 50000000,
   parameter int BASE_FREQUENCY = 1000000,
   parameter int N_CH           = 4,
   parameter int DIV_W          = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(N_CH)-1:0]  cfg_ch,
   input  logic [DIV_W-1:0]         cfg_div,
   input  logic                     start,
   input  logic                     stop,
   output logic [N_CH-1:0]          tick_en,
   output logic                     busy
);

   localparam int PRESCALE = calc_prescale(REF_FREQUENCY, BASE_FREQUENCY);
   localparam int CH_W     = $clog2(N_CH);

   generate
      if (PRESCALE < 2) begin : g_bad_prescale
         $error("tick_scheduler: REF_FREQUENCY/BASE_FREQUENCY must be at least 2");
      end
   endgenerate

   state_t                       state_q, state_d;
   logic [N_CH-1:0][DIV_W-1:0]   div_q, div_d;
   logic [N_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
   logic [N_CH-1:0]              tick_en_q, tick_en_d;
   logic                         busy_q, busy_d;
   logic                         cfg_ready_q, cfg_ready_d;
   logic                         run_en;
   logic                         base_tick;
   logic                         cfg_wr;

   assign run_en = (state_q != IDLE);
   assign cfg_wr = cfg_valid && cfg_ready_q;

   // Prescaler only advances while active and is held at 0 in IDLE.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (run_en),
      .clr   (!run_en),
      .tick  (base_tick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !stop) state_d = RUN;
         RUN:     if (stop)           state_d = DRAIN;
         DRAIN:   if (base_tick)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase

      div_d     = div_q;
      cnt_d     = cnt_q;
      tick_en_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         // A write owns the channel for this cycle: it clears the counter and
         // suppresses any strobe the coinciding base tick would have produced.
         // Out-of-range channel numbers match nothing and are dropped.
         if (cfg_wr && (cfg_ch == CH_W'(i))) begin
            div_d[i] = cfg_div;
            cnt_d[i] = '0;
         end else begin
            if (base_tick && (div_q[i] != '0)) begin
               if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
                  cnt_d[i]     = '0;
                  tick_en_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + DIV_W'(1);
               end
            end
            // The final DRAIN tick still strobes; counters restart from 0 next run.
            if (state_d == IDLE) begin
               cnt_d[i] = '0;
            end
         end
      end

      // busy trails the state by one cycle, so it still covers the last strobe.
      busy_d      = (state_q != IDLE);
      cfg_ready_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         tick_en_q   <= '0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         tick_en_q   <= tick_en_d;
         busy_q      <= busy_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign tick_en   = tick_en_q;
   assign busy      = busy_q;
   assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler
module tb_tick_scheduler;

   localparam int PRE = 50 / 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_ch = '0;
   logic [15:0] cfg_div = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  tick_en;
   logic        busy;

   logic        n5_cfg_valid = 1'b0;
   logic        n5_cfg_ready;
   logic [2:0]  n5_cfg_ch = '0;
   logic [15:0] n5_cfg_div = '0;
   logic        n5_start = 1'b0;
   logic        n5_stop = 1'b0;
   logic [4:0]  n5_tick_en;
   logic        n5_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tick_scheduler #(.REF_FREQUENCY(50), .BASE_FREQUENCY(10), .N_CH(4), .DIV_W(16)) u_dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .start(start), .stop(stop),
      .tick_en(tick_en), .busy(busy)
   );

   tick_scheduler #(.REF_FREQUENCY(50), .BASE_FREQUENCY(10), .N_CH(5), .DIV_W(16)) u_dut5 (
      .clk(clk), .reset(reset), .cfg_valid(n5_cfg_valid), .cfg_ready(n5_cfg_ready),
      .cfg_ch(n5_cfg_ch), .cfg_div(n5_cfg_div), .start(n5_start), .stop(n5_stop),
      .tick_en(n5_tick_en), .busy(n5_busy)
   );

   // Reference model: mode 0 idle / 1 run / 2 drain; elapsed active cycles set
   // the base-tick phase, and each channel strobes whenever the number of base
   // ticks since its last clear is a multiple of its divide ratio.
   int         m_mode = 0;
   int         m_elapsed = 0;
   int         m_since[4] = '{default: 0};
   int         m_div[4] = '{default: 0};
   logic [3:0] m_tick = '0;
   logic       m_busy = 1'b0;
   logic       m_ready = 1'b0;

   task automatic model_step();
      bit bt;
      int nxt;
      if (!reset) begin
         m_mode = 0; m_elapsed = 0; m_tick = '0; m_busy = 1'b0; m_ready = 1'b0;
         for (int i = 0; i < 4; i++) begin m_since[i] = 0; m_div[i] = 0; end
      end else begin
         bt = (m_mode != 0) && ((m_elapsed % PRE) == PRE - 1);
         m_busy = (m_mode != 0);
         for (int i = 0; i < 4; i++) begin
            m_tick[i] = 1'b0;
            if (cfg_valid && m_ready && (int'(cfg_ch) == i)) begin
               m_div[i] = int'(cfg_div);
               m_since[i] = 0;
            end else if (bt && m_div[i] != 0) begin
               m_since[i] = m_since[i] + 1;
               m_tick[i] = ((m_since[i] % m_div[i]) == 0);
            end
         end
         nxt = m_mode;
         if (m_mode == 0 && start && !stop) nxt = 1;
         else if (m_mode == 1 && stop) nxt = 2;
         else if (m_mode == 2 && bt) nxt = 0;
         if (nxt == 0) begin
            m_elapsed = 0;
            for (int i = 0; i < 4; i++) m_since[i] = 0;
         end else if (m_mode != 0) begin
            m_elapsed = m_elapsed + 1;
         end
         m_mode = nxt;
         m_ready = 1'b1;
      end
   endtask

   always @(posedge clk or negedge reset) model_step();

   task automatic test_reset();
      #2;
      checks++;
      if (tick_en !== 4'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold tick_en=%b busy=%b cfg_ready=%b required 0000/0/0", tick_en, busy, cfg_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1 || tick_en !== 4'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release cfg_ready=%b tick_en=%b busy=%b required 1/0000/0", cfg_ready, tick_en, busy);
      end
   endtask

   task automatic test_divide_rates();
      int divs[4] = '{1, 2, 3, 0};
      int first[4] = '{-1, -1, -1, -1};
      int cnt[4] = '{0, 0, 0, 0};
      int exp_first, exp_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cfg_valid = 1'b1; cfg_ch = 2'(i); cfg_div = 16'(divs[i]);
      end
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b1;
      for (int j = 1; j <= 61; j++) begin
         @(negedge clk);
         if (j == 1) start = 1'b0;
         checks++;
         if (tick_en !== m_tick || busy !== m_busy || cfg_ready !== m_ready) begin
            errors++;
            $display("FAIL rates_model j=%0d tick_en=%b busy=%b required %b/%b", j, tick_en, busy, m_tick, m_busy);
         end
         for (int i = 0; i < 4; i++) if (tick_en[i] === 1'b1) begin
            cnt[i]++;
            if (first[i] < 0) first[i] = j;
         end
      end
      for (int i = 0; i < 4; i++) begin
         exp_first = (divs[i] != 0) ? 1 + PRE * divs[i] : -1;
         exp_cnt   = (divs[i] != 0) ? 60 / (PRE * divs[i]) : 0;
         checks++;
         if (first[i] != exp_first || cnt[i] != exp_cnt) begin
            errors++;
            $display("FAIL rates_ch%0d first=%0d count=%0d required %0d/%0d", i, first[i], cnt[i], exp_first, exp_cnt);
         end
      end
   endtask

   // Runs straight after test_divide_rates: base tick 12 fell 2 cycles before stop.
   task automatic test_stop_drain();
      logic [3:0] exp13;
      for (int i = 0; i < 4; i++) exp13[i] = (i == 0) || (i == 1 && 13 % 2 == 0) || (i == 2 && 13 % 3 == 0);
      @(negedge clk);
      stop = 1'b1;
      for (int j = 63; j <= 68; j++) begin
         @(negedge clk);
         if (j == 63) stop = 1'b0;
         checks++;
         if (tick_en !== m_tick || busy !== m_busy) begin
            errors++;
            $display("FAIL drain_model j=%0d tick_en=%b busy=%b required %b/%b", j, tick_en, busy, m_tick, m_busy);
         end
         checks++;
         if (busy !== (j <= 66) || (j == 66 && tick_en !== exp13) || (j >= 67 && tick_en !== 4'b0)) begin
            errors++;
            $display("FAIL drain_timing j=%0d busy=%b tick_en=%b required busy=%b", j, busy, tick_en, j <= 66);
         end
      end
   endtask

   task automatic test_start_stop_same();
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 1) begin start = 1'b0; stop = 1'b0; end
         checks++;
         if (busy !== 1'b0 || tick_en !== 4'b0 || busy !== m_busy) begin
            errors++;
            $display("FAIL start_stop_same j=%0d busy=%b tick_en=%b required 0/0000", j, busy, tick_en);
         end
      end
   endtask

   task automatic test_write_collision();
      int ch1_next = -1;
      @(negedge clk);
      start = 1'b1;
      for (int j = 1; j <= 35; j++) begin
         @(negedge clk);
         if (j == 1) start = 1'b0;
         if (j == 10) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4; end
         if (j == 11) cfg_valid = 1'b0;
         checks++;
         if (tick_en !== m_tick || busy !== m_busy) begin
            errors++;
            $display("FAIL collision_model j=%0d tick_en=%b busy=%b required %b/%b", j, tick_en, busy, m_tick, m_busy);
         end
         if (j == 11) begin
            checks++;
            if (tick_en[1] !== 1'b0 || tick_en[0] !== 1'b1) begin
               errors++;
               $display("FAIL collision_suppress tick_en=%b required ch1=0 ch0=1", tick_en);
            end
         end
         if (j > 11 && tick_en[1] === 1'b1 && ch1_next < 0) ch1_next = j;
      end
      checks++;
      if (ch1_next != 11 + 4 * PRE) begin
         errors++;
         $display("FAIL collision_next ch1 strobe at j=%0d required %0d", ch1_next, 11 + 4 * PRE);
      end
      @(negedge clk);
      stop = 1'b1;
      repeat (12) begin
         @(negedge clk);
         stop = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || tick_en !== 4'b0) begin
         errors++;
         $display("FAIL collision_drain busy=%b tick_en=%b required 0/0000", busy, tick_en);
      end
   endtask

   task automatic test_unmapped_channel();
      int cnt[5] = '{0, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n5_cfg_valid = 1'b1; n5_cfg_ch = 3'(i);
         n5_cfg_div = (i < 5) ? 16'(i + 1) : 16'd0;
      end
      @(negedge clk);
      n5_cfg_valid = 1'b0; n5_start = 1'b1;
      for (int j = 1; j <= 26; j++) begin
         @(negedge clk);
         if (j == 1) n5_start = 1'b0;
         for (int i = 0; i < 5; i++) if (n5_tick_en[i] === 1'b1) cnt[i]++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cnt[i] != 5 / (i + 1)) begin
            errors++;
            $display("FAIL unmapped_ch%0d strobes=%0d required %0d", i, cnt[i], 5 / (i + 1));
         end
      end
      @(negedge clk);
      n5_stop = 1'b1;
      @(negedge clk);
      n5_stop = 1'b0;
   endtask

   task automatic test_random();
      for (int j = 0; j < 400; j++) begin
         @(negedge clk);
         checks++;
         if (tick_en !== m_tick || busy !== m_busy || cfg_ready !== m_ready) begin
            errors++;
            $display("FAIL random_model j=%0d tick_en=%b busy=%b required %b/%b", j, tick_en, busy, m_tick, m_busy);
         end
         cfg_valid = ($urandom_range(3) == 0);
         cfg_ch    = 2'($urandom_range(3));
         cfg_div   = 16'($urandom_range(4));
         start     = ($urandom_range(9) == 0);
         stop      = ($urandom_range(24) == 0);
      end
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0; stop = 1'b1;
      repeat (12) begin
         @(negedge clk);
         stop = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || busy !== m_busy) begin
         errors++;
         $display("FAIL random_drain busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b1;
      for (int j = 1; j <= 21; j++) begin
         @(negedge clk);
         if (j == 1) start = 1'b0;
      end
      checks++;
      if (tick_en[0] !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre tick_en=%b busy=%b required ch0=1 busy=1", tick_en, busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (tick_en !== 4'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset tick_en=%b busy=%b cfg_ready=%b required 0000/0/0", tick_en, busy, cfg_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      // Divide ratios were cleared by reset, so a run must stay silent.
      @(negedge clk);
      start = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         if (j == 1) start = 1'b0;
         checks++;
         if (tick_en !== 4'b0 || busy !== m_busy) begin
            errors++;
            $display("FAIL midrun_cleared j=%0d tick_en=%b busy=%b required 0000/%b", j, tick_en, busy, m_busy);
         end
      end
      @(negedge clk);
      stop = 1'b1;
      repeat (12) begin
         @(negedge clk);
         stop = 1'b0;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_drain busy=%b required 0", busy);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_divide_rates();
      test_stop_drain();
      test_start_stop_same();
      test_write_collision();
      test_unmapped_channel();
      test_random();
      test_reset_midrun();
      test_divide_rates();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
